unary_stream_encoder: RTL and testbench

- Converts a binary magnitude into an evenly spread unary bitstream of exactly INPUT_WIDTH bits.
- Feeds the unary arithmetic units: `y` drives their bit input `a`, and `valid` drives their `ready`.
- Uses a Bresenham-style error accumulator, so every prefix of the stream is the closest integer approximation of the final ratio. Online consumers therefore get tight early bounds.
- Streams are loaded with a valid/ready handshake, can be paused with `hold`, and signal `done` on the last bit.

---
 rtl/unary_stream_encoder.sv | 140 ++++++++++++++
 tb/tb_unary_stream_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_stream_encoder.sv
// -----------------------------------------------------------------------------
// unary_stream_encoder
//
// Turns a binary magnitude into an evenly spread unary bitstream of exactly
// INPUT_WIDTH bits. A Bresenham-style error accumulator places the ones so that
// every prefix of the stream is the closest integer approximation of the final
// ratio value/INPUT_WIDTH. Online consumers therefore get tight early bounds.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   in_valid  in   value is presented for loading
//   value     in   number of ones to emit (clamped to INPUT_WIDTH)
//   in_ready  out  high only while idle; load on in_valid && in_ready
//   hold      in   pauses emission while high (ignored when idle)
//   y         out  current stream bit, 0 whenever valid is 0
//   valid     out  y carries a stream bit this cycle
//   done      out  one-cycle pulse together with the last bit
//   busy      out  high while a stream is running
// -----------------------------------------------------------------------------
module unary_stream_encoder #(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [COUNT_WIDTH-1:0] value,
    output logic                   in_ready,
    input  logic                   hold,
    output logic                   y,
    output logic                   valid,
    output logic                   done,
    output logic                   busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Constants sized to the datapaths they are compared against.
    localparam logic [COUNT_WIDTH-1:0] V_MAX     = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_BIT  = COUNT_WIDTH'(INPUT_WIDTH - 1);
    localparam logic [COUNT_WIDTH:0]   FULL      = (COUNT_WIDTH + 1)'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH:0]   ACC_START = (COUNT_WIDTH + 1)'(INPUT_WIDTH / 2);

    state_t                 state_q,     state_d;
    logic [COUNT_WIDTH-1:0] v_reg_q,     v_reg_d;
    logic [COUNT_WIDTH:0]   acc_q,       acc_d;
    logic [COUNT_WIDTH-1:0] bit_count_q, bit_count_d;
    logic                   y_q,         y_d;
    logic                   valid_q,     valid_d;
    logic                   done_q,      done_d;
    logic                   busy_q,      busy_d;
    logic                   in_ready_q,  in_ready_d;

    // acc stays below INPUT_WIDTH and v_reg is at most INPUT_WIDTH, so the sum
    // is below 2*INPUT_WIDTH and fits in COUNT_WIDTH+1 bits.
    logic [COUNT_WIDTH:0]   sum;

    always_comb begin
        state_d     = state_q;
        v_reg_d     = v_reg_q;
        acc_d       = acc_q;
        bit_count_d = bit_count_q;
        y_d         = 1'b0;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        sum         = acc_q + {1'b0, v_reg_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    v_reg_d     = (value > V_MAX) ? V_MAX : value;
                    // Starting at half scale centres the rounding of every prefix.
                    acc_d       = ACC_START;
                    bit_count_d = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                // While held, the accumulator and count are frozen so the
                // stream resumes exactly where it paused.
                if (!hold) begin
                    if (sum >= FULL) begin
                        y_d   = 1'b1;
                        acc_d = sum - FULL;
                    end else begin
                        y_d   = 1'b0;
                        acc_d = sum;
                    end
                    valid_d     = 1'b1;
                    bit_count_d = bit_count_q + 1'b1;
                    if (bit_count_q == LAST_BIT) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake/status outputs follow the next state so they change on
        // the same edge as the transition.
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            v_reg_q     <= '0;
            acc_q       <= '0;
            bit_count_q <= '0;
            y_q         <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            v_reg_q     <= v_reg_d;
            acc_q       <= acc_d;
            bit_count_q <= bit_count_d;
            y_q         <= y_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign y        = y_q;
    assign valid    = valid_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign in_ready = in_ready_q;

endmodule

// File: tb/tb_unary_stream_encoder.sv
// -----------------------------------------------------------------------------
// tb_unary_stream_encoder
//
// Self-checking bench for unary_stream_encoder. Expected bits come from the
// closed-form prefix count floor((W/2 + k*v)/W); they are pushed to a queue at
// load time and popped as the DUT emits valid bits.
// -----------------------------------------------------------------------------
module tb_unary_stream_encoder;

    localparam int W  = 32;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [CW-1:0] value;
    logic          in_ready;
    logic          hold;
    logic          y;
    logic          valid;
    logic          done;
    logic          busy;

    unary_stream_encoder #(
        .INPUT_WIDTH (W),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .value    (value),
        .in_ready (in_ready),
        .hold     (hold),
        .y        (y),
        .valid    (valid),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic y;
        logic done;
    } exp_t;

    typedef struct {
        int val;
        int hold_after;
        int hold_len;
        int exp_ones;
        int exp_first;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected stream from the prefix formula: bit k is the increase of the
    // ones count between prefix k-1 and prefix k.
    task automatic push_expected(input int val);
        int   c;
        exp_t e;
        c = (val > W) ? W : val;
        for (int k = 1; k <= W; k++) begin
            e.y    = (((W / 2 + k * c) / W) - ((W / 2 + (k - 1) * c) / W)) != 0;
            e.done = (k == W);
            sb.push_back(e);
        end
    endtask

    task automatic load(input string tag, input int val);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_ready_before_load"}, int'(in_ready), 1);
        in_valid = 1'b1;
        value    = CW'(val);
        @(posedge clk);
        push_expected(val);
        #1;
        in_valid = 1'b0;
        check({tag, "_in_ready_after_load"}, int'(in_ready), 0);
        check({tag, "_busy_after_load"}, int'(busy), 1);
        check({tag, "_no_bit_at_load"}, int'(valid), 0);
        $display("load %s: value=%0d", tag, val);
    endtask

    // Runs one stream to completion, optionally holding after a given bit and
    // optionally presenting a competing load while running.
    task automatic collect(input string tag, input int hold_after, input int hold_len,
                           input bit inject, input int exp_ones, input int exp_first);
        int   bits, ones, dones, cyc, held, first;
        bit   hold_prev;
        exp_t e;
        bits = 0; ones = 0; dones = 0; cyc = 0; held = 0; first = 0;
        hold      = 1'b0;
        hold_prev = 1'b0;
        if (inject) begin
            in_valid = 1'b1;
            value    = CW'(5);
        end
        while (bits < W && cyc < W + 50) begin
            @(posedge clk);
            #1;
            cyc++;
            if (hold_prev) begin
                check({tag, "_valid_while_held"}, int'(valid), 0);
                held++;
            end
            if (valid) begin
                bits++;
                if (sb.size() == 0) begin
                    check({tag, "_scoreboard_empty"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("%s_y_bit%0d", tag, bits), int'(y), int'(e.y));
                    check($sformatf("%s_done_bit%0d", tag, bits), int'(done), int'(e.done));
                end
                if (y) begin
                    ones++;
                    if (first == 0) first = bits;
                end
                if (done) dones++;
            end else begin
                check({tag, "_y_without_valid"}, int'(y), 0);
                check({tag, "_done_without_valid"}, int'(done), 0);
            end
            hold      = (hold_after >= 0) && (bits == hold_after) && (held < hold_len);
            hold_prev = hold;
        end
        hold = 1'b0;
        if (inject) in_valid = 1'b0;
        check({tag, "_bits"}, bits, W);
        check({tag, "_ones"}, ones, exp_ones);
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_cycles"}, cyc, W + hold_len);
        check({tag, "_first_one"}, first, exp_first);
        check({tag, "_in_ready_at_end"}, int'(in_ready), 1);
        check({tag, "_busy_at_end"}, int'(busy), 0);
        $display("stream %s: bits=%0d ones=%0d cycles=%0d first_one=%0d", tag, bits, ones, cyc, first);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bits;

        vecs[0] = '{0,  -1, 0, 0,  0};
        vecs[1] = '{16, -1, 0, 16, 1};
        vecs[2] = '{1,  -1, 0, 1,  16};
        vecs[3] = '{40, -1, 0, 32, 1};
        vecs[4] = '{31, -1, 0, 31, 1};
        vecs[5] = '{16,  5, 3, 16, 1};

        reset    = 1'b0;
        in_valid = 1'b0;
        hold     = 1'b0;
        value    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_y", int'(y), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        reset = 1'b1;

        // Hold has no effect while idle.
        hold = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_valid", int'(valid), 0);
        check("idle_hold_in_ready", int'(in_ready), 1);
        hold = 1'b0;

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            load(tag, vecs[i].val);
            collect(tag, vecs[i].hold_after, vecs[i].hold_len, 1'b0,
                    vecs[i].exp_ones, vecs[i].exp_first);
        end

        // A competing load during RUN is ignored; the next one is taken on
        // the first edge after done.
        load("ignore10", 10);
        collect("ignore10", -1, 0, 1'b1, 10, 2);
        check("b2b_in_ready_after_done", int'(in_ready), 1);
        load("b2b5", 5);
        collect("b2b5", -1, 0, 1'b0, 5, 4);

        // Reset mid-stream aborts immediately.
        load("abort20", 20);
        bits = 0;
        for (int c = 0; c < W + 10 && bits < 12; c++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                bits++;
                void'(sb.pop_front());
            end
        end
        check("abort_reached_bit12", bits, 12);
        #2;
        reset = 1'b0;
        #1;
        check("abort_y", int'(y), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_done", int'(done), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 1);
        $display("abort: reset asserted after bit %0d", bits);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        load("after_reset7", 7);
        collect("after_reset7", -1, 0, 1'b0, 7, 3);

        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
